// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one single-port data memory between two requesters.
// Optional atomic lock support is enabled with the DMEM_ARB_LOCK_EN macro.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
`ifdef DMEM_ARB_LOCK_EN
  input  logic          lock0,
  input  logic          lock1,
`endif
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  logic rr_last_r;
  logic eff_req0_s;
  logic eff_req1_s;
  logic win0_s;
  logic win1_s;

`ifdef DMEM_ARB_LOCK_EN
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED0  = 2'd1,
    LOCKED1  = 2'd2
  } lock_state_t;

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_MAX - 1);

  lock_state_t   state_r;
  lock_state_t   state_nxt_s;
  logic [CW-1:0] lock_cnt_r;
  logic [CW-1:0] lock_cnt_nxt_s;

  // While a port holds the lock the other port's request is masked out
  always_comb begin
    eff_req0_s = req0;
    eff_req1_s = req1;
    case (state_r)
      LOCKED0: eff_req1_s = 1'b0;
      LOCKED1: eff_req0_s = 1'b0;
      default: begin
        eff_req0_s = req0;
        eff_req1_s = req1;
      end
    endcase
  end

  // Lock FSM next state: release on lock drop, request drop or burst limit
  always_comb begin
    state_nxt_s    = state_r;
    lock_cnt_nxt_s = lock_cnt_r;
    case (state_r)
      UNLOCKED: begin
        if (gnt0 && lock0) begin
          state_nxt_s    = LOCKED0;
          lock_cnt_nxt_s = {{(CW-1){1'b0}}, 1'b1};
        end else if (gnt1 && lock1) begin
          state_nxt_s    = LOCKED1;
          lock_cnt_nxt_s = {{(CW-1){1'b0}}, 1'b1};
        end else begin
          state_nxt_s = UNLOCKED;
        end
      end
      LOCKED0: begin
        if (!req0) begin
          state_nxt_s = UNLOCKED;
        end else if (gnt0) begin
          if (!lock0 || (lock_cnt_r == LOCK_LAST)) begin
            state_nxt_s = UNLOCKED;
          end else begin
            lock_cnt_nxt_s = lock_cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end else begin
          state_nxt_s = LOCKED0;
        end
      end
      LOCKED1: begin
        if (!req1) begin
          state_nxt_s = UNLOCKED;
        end else if (gnt1) begin
          if (!lock1 || (lock_cnt_r == LOCK_LAST)) begin
            state_nxt_s = UNLOCKED;
          end else begin
            lock_cnt_nxt_s = lock_cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end else begin
          state_nxt_s = LOCKED1;
        end
      end
      default: begin
        state_nxt_s    = UNLOCKED;
        lock_cnt_nxt_s = {CW{1'b0}};
      end
    endcase
  end

  // Lock FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= UNLOCKED;
      lock_cnt_r <= {CW{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      lock_cnt_r <= lock_cnt_nxt_s;
    end
  end
`else
  assign eff_req0_s = req0;
  assign eff_req1_s = req1;
`endif

  // Round-robin pick: under contention the port that did not win last time goes
  always_comb begin
    win0_s = 1'b0;
    win1_s = 1'b0;
    if (eff_req0_s && eff_req1_s) begin
      win0_s = rr_last_r;
      win1_s = ~rr_last_r;
    end else begin
      win0_s = eff_req0_s;
      win1_s = eff_req1_s;
    end
  end

  assign gnt0 = win0_s & rst_n;
  assign gnt1 = win1_s & rst_n;

  // Winner steers the memory interface; idle cycles present all zeros
  always_comb begin
    mem_addr  = {AW{1'b0}};
    mem_wdata = {DW{1'b0}};
    mem_we    = 1'b0;
    if (gnt0) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
      mem_we    = we0;
    end else if (gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_we    = we1;
    end else begin
      mem_we    = 1'b0;
    end
  end

  // Round-robin history and registered read return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_r <= 1'b1;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= {DW{1'b0}};
      rdata1    <= {DW{1'b0}};
    end else begin
      if (gnt1) begin
        rr_last_r <= 1'b1;
      end else if (gnt0) begin
        rr_last_r <= 1'b0;
      end else begin
        rr_last_r <= rr_last_r;
      end
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 && !we0) begin
        rdata0 <= mem_rdata;
      end
      if (gnt1 && !we1) begin
        rdata1 <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a grant/memory model issues expected read
// returns into per-port queues, and an independent monitor retires them.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;
`ifdef DMEM_ARB_LOCK_EN
  logic       lock0 = 1'b0;
  logic       lock1 = 1'b0;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(8), .DW(8), .LOCK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
`ifdef DMEM_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  // The data memory itself: combinational read, write on the rising edge
  logic [7:0] env_mem [256];
  assign mem_rdata = env_mem[mem_addr];
  initial begin
    for (int i = 0; i < 256; i++) env_mem[i] = 8'(i * 37 + 11);
    forever begin
      @(posedge clk);
      if (mem_we === 1'b1) env_mem[mem_addr] = mem_wdata;
    end
  end

  typedef struct { bit req; bit we; bit [7:0] addr; bit [7:0] wdata; } txn_t;
  typedef struct { int due; bit [7:0] data; } exp_t;

  txn_t     tq0[$], tq1[$];
  txn_t     cur0, cur1;
  bit       busy0, busy1;
  exp_t     eq0[$], eq1[$];
  bit [7:0] ref_mem [256];
  bit       model_last;
  int       cyc = 0;
  int       n_vec = 0;
  int       n_err = 0;
  bit [7:0] mon_last0, mon_last1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: retire expected read returns exactly one cycle after their grant
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      mon_last0 = 8'h00;
      mon_last1 = 8'h00;
      chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
      chk("rst_rdata", {16'd0, rdata1, rdata0}, 32'd0);
    end else begin
      if (rvalid0 === 1'b1) begin
        if (eq0.size() > 0 && eq0[0].due == cyc) begin
          e = eq0.pop_front();
          chk("rdata0", rdata0, e.data);
          mon_last0 = e.data;
        end else chk("rvalid0_spurious", rvalid0, 32'd0);
      end else if (eq0.size() > 0 && eq0[0].due == cyc) begin
        void'(eq0.pop_front());
        chk("rvalid0_missing", rvalid0, 32'd1);
      end else chk("rdata0_hold", rdata0, mon_last0);
      if (rvalid1 === 1'b1) begin
        if (eq1.size() > 0 && eq1[0].due == cyc) begin
          e = eq1.pop_front();
          chk("rdata1", rdata1, e.data);
          mon_last1 = e.data;
        end else chk("rvalid1_spurious", rvalid1, 32'd0);
      end else if (eq1.size() > 0 && eq1[0].due == cyc) begin
        void'(eq1.pop_front());
        chk("rvalid1_missing", rvalid1, 32'd1);
      end else chk("rdata1_hold", rdata1, mon_last1);
    end
  end

  task automatic drive();
    req0 = cur0.req; we0 = cur0.we; addr0 = cur0.addr; wdata0 = cur0.wdata;
    req1 = cur1.req; we1 = cur1.we; addr1 = cur1.addr; wdata1 = cur1.wdata;
  endtask

  // Model of one granted access: check the memory bus and predict the read return
  task automatic grant_model(input txn_t t, input int p);
    exp_t e;
    chk("mem_addr", mem_addr, t.addr);
    chk("mem_we", mem_we, t.we);
    if (t.we) begin
      chk("mem_wdata", mem_wdata, t.wdata);
      ref_mem[t.addr] = t.wdata;
    end else begin
      e.due  = cyc + 1;
      e.data = ref_mem[t.addr];
      if (p == 0) eq0.push_back(e); else eq1.push_back(e);
    end
    model_last = (p == 1);
    if (p == 0) busy0 = 1'b0; else busy1 = 1'b1 ^ 1'b1;
  endtask

  task automatic step();
    bit w0, w1;
    if (!busy0) begin
      if (tq0.size() > 0) cur0 = tq0.pop_front(); else cur0.req = 1'b0;
      busy0 = cur0.req;
    end
    if (!busy1) begin
      if (tq1.size() > 0) cur1 = tq1.pop_front(); else cur1.req = 1'b0;
      busy1 = cur1.req;
    end
    drive();
    @(negedge clk);
    // Only requester wins; under contention the port that lost last time wins
    if (cur0.req && cur1.req) begin
      w0 = model_last;
      w1 = !model_last;
    end else begin
      w0 = cur0.req;
      w1 = cur1.req;
    end
    chk("gnt0", gnt0, w0);
    chk("gnt1", gnt1, w1);
    if (w0) grant_model(cur0, 0);
    else if (w1) grant_model(cur1, 1);
    else chk("mem_we_idle", mem_we, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_drain(input int max_cyc);
    int n = 0;
    while ((tq0.size() > 0 || tq1.size() > 0 || busy0 || busy1) && n < max_cyc) begin
      step();
      n++;
    end
    if (n >= max_cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: actual %0d cycles required < %0d", n, max_cyc);
    end
    step();
    step();
  endtask

  task automatic do_reset(input int ncyc);
    rst_n = 1'b0;
    eq0.delete();
    eq1.delete();
    model_last = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
      chk("rst_mem_we", mem_we, 32'd0);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  function automatic txn_t rnd_txn();
    txn_t t;
    t.req   = ($urandom_range(0, 4) != 0);
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
    t.wdata = 8'($urandom);
    return t;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
    busy0 = 1'b0;
    busy1 = 1'b0;

    // Reset with both ports requesting, then port 0 must win first
    cur0 = '{1'b1, 1'b0, 8'h05, 8'h00};
    cur1 = '{1'b1, 1'b0, 8'h06, 8'h00};
    busy0 = 1'b1;
    busy1 = 1'b1;
    drive();
    do_reset(3);
    run_drain(20);

    // Write 0xA5 to 0x10 through port 0, read it back through port 1
    tq0.push_back('{1'b1, 1'b1, 8'h10, 8'hA5});
    tq1.push_back('{1'b0, 1'b0, 8'h00, 8'h00});
    tq1.push_back('{1'b1, 1'b0, 8'h10, 8'h00});
    run_drain(20);

    // Continuous contention must alternate
    for (int i = 0; i < 6; i++) begin
      tq0.push_back('{1'b1, 1'b0, 8'(8'h40 + i), 8'h00});
      tq1.push_back('{1'b1, 1'b0, 8'(8'h50 + i), 8'h00});
    end
    run_drain(40);

    // Lone requester streams reads back-to-back
    for (int i = 0; i < 4; i++) tq1.push_back('{1'b1, 1'b0, 8'(i), 8'h00});
    run_drain(20);

    // Reset pulse during a port 0 write, then contention resumes with port 0
    cur0 = '{1'b1, 1'b1, 8'h20, 8'h77};
    busy0 = 1'b1;
    drive();
    do_reset(1);
    cur1 = '{1'b1, 1'b0, 8'h20, 8'h00};
    busy1 = 1'b1;
    run_drain(20);

`ifdef DMEM_ARB_LOCK_EN
    // Locked burst of four port 0 grants, then port 1 gets through
    do_reset(1);
    cur0 = '{1'b1, 1'b1, 8'h30, 8'h3C};
    cur1 = '{1'b1, 1'b1, 8'h31, 8'hC3};
    lock0 = 1'b1;
    drive();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lock_gnt0", gnt0, (i < 4) ? 32'd1 : 32'd0);
      chk("lock_gnt1", gnt1, (i == 4) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    lock0 = 1'b0;
    ref_mem[8'h30] = 8'h3C;
    ref_mem[8'h31] = 8'hC3;
    model_last = 1'b1;
    busy0 = 1'b0;
    busy1 = 1'b0;
    cur0.req = 1'b0;
    cur1.req = 1'b0;
    tq0.push_back('{1'b1, 1'b0, 8'h30, 8'h00});
    tq1.push_back('{1'b1, 1'b0, 8'h31, 8'h00});
    run_drain(20);
`endif

    // Randomised traffic with idle gaps and clustered addresses
    for (int i = 0; i < 300; i++) begin
      tq0.push_back(rnd_txn());
      tq1.push_back(rnd_txn());
    end
    run_drain(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
